// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and renderer state encoding.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BORDER_W = 4;

    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;
endpackage

// File: rtl/square_renderer_axis_bounce.sv
// Single-axis bounce step: moves pos by speed toward dir and clamps/reflects at min_pos/max_pos.
module axis_bounce #(
    parameter int W = 10
) (
    input  logic [W-1:0] pos,
    input  logic         dir_pos,
    input  logic [2:0]   speed,
    input  logic [W-1:0] min_pos,
    input  logic [W-1:0] max_pos,
    output logic [W-1:0] pos_next,
    output logic         dir_pos_next,
    output logic         wall
);
    logic [10:0] pos_ext;
    logic [10:0] spd_ext;
    logic [10:0] fwd_ext;
    logic [10:0] min_ext;
    logic [10:0] max_ext;

    // 11-bit arithmetic so neither the forward sum nor the reverse compare can wrap
    assign pos_ext = 11'(pos);
    assign spd_ext = 11'(speed);
    assign min_ext = 11'(min_pos);
    assign max_ext = 11'(max_pos);
    assign fwd_ext = pos_ext + spd_ext;

    always_comb begin
        pos_next     = pos;
        dir_pos_next = dir_pos;
        wall         = 1'b0;
        if (speed != 3'd0) begin
            if (dir_pos) begin
                if (fwd_ext >= max_ext) begin
                    pos_next     = max_pos;
                    dir_pos_next = 1'b0;
                    wall         = 1'b1;
                end else begin
                    pos_next = W'(fwd_ext);
                end
            end else begin
                if (pos_ext < min_ext + spd_ext) begin
                    pos_next     = min_pos;
                    dir_pos_next = 1'b1;
                    wall         = 1'b1;
                end else begin
                    pos_next = W'(pos_ext - spd_ext);
                end
            end
        end
    end
endmodule

// File: rtl/square_renderer.sv
// Bouncing-square pixel generator behind the VGA timing controller.
// Define BORDER_EN to draw a 4-pixel white frame and keep the square inside it.
module square_renderer
    import vga_pkg::*;
#(
    parameter int   SIZE    = 32,
    parameter int   X_START = 304,
    parameter int   Y_START = 224,
    parameter rgb_t FG_RGB  = 12'hFFF,
    parameter rgb_t BG_RGB  = 12'h00F,
    parameter rgb_t HIT_RGB = 12'hF00
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        pixel_strobe,
    input  logic        active,
    input  logic        animate,
    input  logic [9:0]  xPos,
    input  logic [8:0]  yPos,
    input  logic        hSync_in,
    input  logic        vSync_in,
    input  logic        move_en,
    input  logic [2:0]  speed,
    output logic [11:0] rgb,
    output logic        hSync_out,
    output logic        vSync_out,
    output logic [7:0]  bounce_count,
    output logic        hit
);
`ifdef BORDER_EN
    localparam int BW = BORDER_W;
`else
    localparam int BW = 0;
`endif
    localparam logic [9:0] X_MIN = 10'(BW);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BW - SIZE);
    localparam logic [8:0] Y_MIN = 9'(BW);
    localparam logic [8:0] Y_MAX = 9'(V_ACTIVE - BW - SIZE);

    state_t      state_reg;
    logic [9:0]  sq_x_reg;
    logic [8:0]  sq_y_reg;
    logic        dx_pos_reg;
    logic        dy_pos_reg;
    rgb_t        rgb_reg;
    logic        hsync_reg;
    logic        vsync_reg;
    logic [7:0]  bounce_reg;
    logic        hit_reg;

    logic [9:0]  sq_x_next;
    logic [8:0]  sq_y_next;
    logic        dx_pos_next;
    logic        dy_pos_next;
    logic        x_wall;
    logic        y_wall;
    logic        any_wall;

    axis_bounce #(.W(10)) u_axis_x (
        .pos          (sq_x_reg),
        .dir_pos      (dx_pos_reg),
        .speed        (speed),
        .min_pos      (X_MIN),
        .max_pos      (X_MAX),
        .pos_next     (sq_x_next),
        .dir_pos_next (dx_pos_next),
        .wall         (x_wall)
    );

    axis_bounce #(.W(9)) u_axis_y (
        .pos          (sq_y_reg),
        .dir_pos      (dy_pos_reg),
        .speed        (speed),
        .min_pos      (Y_MIN),
        .max_pos      (Y_MAX),
        .pos_next     (sq_y_next),
        .dir_pos_next (dy_pos_next),
        .wall         (y_wall)
    );

    // A corner counts as a single bounce
    assign any_wall = x_wall | y_wall;

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_sq;
    logic        in_border;
    rgb_t        pix_rgb;

    assign x_end = 11'(sq_x_reg) + 11'(SIZE - 1);
    assign y_end = 11'(sq_y_reg) + 11'(SIZE - 1);
    assign in_sq = (xPos >= sq_x_reg) && (11'(xPos) <= x_end) &&
                   (yPos >= sq_y_reg) && (11'(yPos) <= y_end);

`ifdef BORDER_EN
    localparam logic [9:0] X_BORDER_LO = 10'(BORDER_W);
    localparam logic [9:0] X_BORDER_HI = 10'(H_ACTIVE - 1 - BORDER_W);
    localparam logic [8:0] Y_BORDER_LO = 9'(BORDER_W);
    localparam logic [8:0] Y_BORDER_HI = 9'(V_ACTIVE - 1 - BORDER_W);
    assign in_border = (xPos < X_BORDER_LO) || (xPos > X_BORDER_HI) ||
                       (yPos < Y_BORDER_LO) || (yPos > Y_BORDER_HI);
`else
    assign in_border = 1'b0;
`endif

    always_comb begin
        pix_rgb = BG_RGB;
        if (!active) begin
            pix_rgb = '0;
        end else if (in_border) begin
            pix_rgb = 12'hFFF;
        end else if (in_sq) begin
            pix_rgb = (state_reg == HIT) ? HIT_RGB : FG_RGB;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_reg  <= IDLE;
            sq_x_reg   <= 10'(X_START);
            sq_y_reg   <= 9'(Y_START);
            dx_pos_reg <= 1'b1;
            dy_pos_reg <= 1'b1;
            rgb_reg    <= '0;
            hsync_reg  <= 1'b1;
            vsync_reg  <= 1'b1;
            bounce_reg <= 8'd0;
            hit_reg    <= 1'b0;
        end else begin
            hit_reg <= 1'b0;
            if (pixel_strobe) begin
                hsync_reg <= hSync_in;
                vsync_reg <= vSync_in;
                rgb_reg   <= pix_rgb;
            end
            // Position only changes at end of frame so the square never tears
            if (animate) begin
                case (state_reg)
                    IDLE: begin
                        if (move_en) begin
                            state_reg <= RUN;
                        end
                    end
                    RUN, HIT: begin
                        if (!move_en) begin
                            state_reg <= IDLE;
                        end else begin
                            sq_x_reg   <= sq_x_next;
                            sq_y_reg   <= sq_y_next;
                            dx_pos_reg <= dx_pos_next;
                            dy_pos_reg <= dy_pos_next;
                            if (any_wall) begin
                                state_reg <= HIT;
                                hit_reg   <= 1'b1;
                                if (bounce_reg != 8'hFF) begin
                                    bounce_reg <= bounce_reg + 8'd1;
                                end
                            end else begin
                                state_reg <= RUN;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign rgb          = rgb_reg;
    assign hSync_out    = hsync_reg;
    assign vSync_out    = vsync_reg;
    assign bounce_count = bounce_reg;
    assign hit          = hit_reg;
endmodule

// File: tb/tb_square_renderer.sv
// Randomised self-checking bench for square_renderer against a frame-level square model.
module tb_square_renderer;
    localparam int SIZE = 32;
`ifdef BORDER_EN
    localparam int BW = 4;
`else
    localparam int BW = 0;
`endif
    localparam int LO_X = BW;
    localparam int HI_X = 640 - BW;
    localparam int LO_Y = BW;
    localparam int HI_Y = 480 - BW;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HIT  = 2;

    logic        clk_25mhz = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_strobe = 1'b0;
    logic        active = 1'b0;
    logic        animate = 1'b0;
    logic [9:0]  xPos = '0;
    logic [8:0]  yPos = '0;
    logic        hSync_in = 1'b1;
    logic        vSync_in = 1'b1;
    logic        move_en = 1'b0;
    logic [2:0]  speed = '0;
    logic [11:0] rgb;
    logic        hSync_out;
    logic        vSync_out;
    logic [7:0]  bounce_count;
    logic        hit;

    int tests_run = 0;
    int tests_failed = 0;

    // Model of the square, tracked per frame
    int m_sx, m_sy, m_dx, m_dy, m_st, m_bc;
    bit m_hit;

    always #20 clk_25mhz = ~clk_25mhz;

    square_renderer dut (
        .clk_25mhz    (clk_25mhz),
        .reset        (reset),
        .pixel_strobe (pixel_strobe),
        .active       (active),
        .animate      (animate),
        .xPos         (xPos),
        .yPos         (yPos),
        .hSync_in     (hSync_in),
        .vSync_in     (vSync_in),
        .move_en      (move_en),
        .speed        (speed),
        .rgb          (rgb),
        .hSync_out    (hSync_out),
        .vSync_out    (vSync_out),
        .bounce_count (bounce_count),
        .hit          (hit)
    );

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    function automatic void model_reset();
        m_sx = 304; m_sy = 224; m_dx = 1; m_dy = 1;
        m_st = M_IDLE; m_bc = 0; m_hit = 0;
    endfunction

    function automatic void step_axis(inout int p, inout int d, input int spd,
                                      input int lo, input int hi, output bit wall);
        wall = 0;
        if (spd == 0) return;
        if (d > 0) begin
            if (p + spd + SIZE >= hi) begin p = hi - SIZE; d = -1; wall = 1; end
            else p = p + spd;
        end else begin
            if (p - spd < lo) begin p = lo; d = 1; wall = 1; end
            else p = p - spd;
        end
    endfunction

    function automatic void model_animate(input int spd, input bit men);
        bit wx, wy;
        m_hit = 0;
        if (m_st == M_IDLE) begin
            if (men) m_st = M_RUN;
        end else if (!men) begin
            m_st = M_IDLE;
        end else begin
            step_axis(m_sx, m_dx, spd, LO_X, HI_X, wx);
            step_axis(m_sy, m_dy, spd, LO_Y, HI_Y, wy);
            if (wx || wy) begin
                m_st = M_HIT;
                m_hit = 1;
                if (m_bc < 255) m_bc = m_bc + 1;
            end else begin
                m_st = M_RUN;
            end
        end
    endfunction

    function automatic logic [11:0] exp_color(input int x, input int y, input bit act);
        if (!act) return 12'h000;
        if (BW > 0 && (x < BW || x > 639 - BW || y < BW || y > 479 - BW)) return 12'hFFF;
        if (x >= m_sx && x < m_sx + SIZE && y >= m_sy && y < m_sy + SIZE)
            return (m_st == M_HIT) ? 12'hF00 : 12'hFFF;
        return 12'h00F;
    endfunction

    task automatic do_animate(input int spd, input bit men, input bit verbose);
        speed = 3'(spd);
        move_en = men;
        pixel_strobe = 1'b0;
        animate = 1'b1;
        tick();
        animate = 1'b0;
        model_animate(spd, men);
        if (verbose)
            $display("[TB] animate speed=%0d move_en=%0d -> sq=(%0d,%0d) state=%0d hit=%0d bc=%0d",
                     spd, men, m_sx, m_sy, m_st, hit, bounce_count);
        tests_run++;
        if (hit !== m_hit) begin
            tests_failed++;
            $display("FAIL hit_pulse: got %0b expected %0b", hit, m_hit);
        end
        tests_run++;
        if (bounce_count !== 8'(m_bc)) begin
            tests_failed++;
            $display("FAIL bounce_count: got %0d expected %0d", bounce_count, m_bc);
        end
        if (m_hit) begin
            tick();
            tests_run++;
            if (hit !== 1'b0) begin
                tests_failed++;
                $display("FAIL hit_one_cycle: got %0b expected 0", hit);
            end
        end
    endtask

    task automatic probe(input int x, input int y, input bit act, input string tag);
        logic [11:0] exp;
        xPos = 10'(x);
        yPos = 9'(y);
        active = act;
        pixel_strobe = 1'b1;
        exp = exp_color(x, y, act);
        tick();
        pixel_strobe = 1'b0;
        $display("[TB] pixel %s (%0d,%0d) act=%0b rgb=%03h", tag, x, y, act, rgb);
        tests_run++;
        if (rgb !== exp) begin
            tests_failed++;
            $display("FAIL rgb_%s: at (%0d,%0d) got %03h expected %03h", tag, x, y, rgb, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (rgb !== 12'h000 || hSync_out !== 1'b1 || vSync_out !== 1'b1 ||
            bounce_count !== 8'd0 || hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got rgb=%03h hs=%0b vs=%0b bc=%0d hit=%0b expected 000 1 1 0 0",
                     rgb, hSync_out, vSync_out, bounce_count, hit);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 3; i++) do_animate(4, 1'b0, 1'b1);
        probe(304, 224, 1'b1, "idle_tl");
        probe(335, 255, 1'b1, "idle_br");
        probe(0, 0, 1'b1, "idle_bg");
    endtask

    task automatic test_start_move();
        do_animate(4, 1'b1, 1'b1);
        probe(304, 224, 1'b1, "start_nostep");
        do_animate(4, 1'b1, 1'b1);
        probe(308, 228, 1'b1, "step_tl");
        probe(307, 228, 1'b1, "step_left");
        probe(339, 259, 1'b1, "step_br");
        probe(340, 259, 1'b1, "step_right");
    endtask

    task automatic test_pixel_pipeline();
        probe(310, 230, 1'b0, "inactive");
        hSync_in = 1'b0;
        vSync_in = 1'b0;
        probe(0, 0, 1'b0, "sync_low");
        tests_run++;
        if (hSync_out !== 1'b0 || vSync_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL sync_follow: got hs=%0b vs=%0b expected 0 0", hSync_out, vSync_out);
        end
        // Without a strobe nothing may change
        hSync_in = 1'b1;
        vSync_in = 1'b1;
        xPos = 10'd310;
        yPos = 9'd240;
        active = 1'b1;
        pixel_strobe = 1'b0;
        tick();
        tests_run++;
        if (hSync_out !== 1'b0 || vSync_out !== 1'b0 || rgb !== 12'h000) begin
            tests_failed++;
            $display("FAIL strobe_hold: got hs=%0b vs=%0b rgb=%03h expected 0 0 000",
                     hSync_out, vSync_out, rgb);
        end
        probe(0, 0, 1'b1, "sync_high");
        tests_run++;
        if (hSync_out !== 1'b1 || vSync_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL sync_return: got hs=%0b vs=%0b expected 1 1", hSync_out, vSync_out);
        end
    endtask

    task automatic test_random_run();
        int spd;
        bit men;
        for (int f = 0; f < 80; f++) begin
            spd = $urandom_range(0, 7);
            men = ($urandom_range(0, 9) != 0);
            do_animate(spd, men, 1'b1);
            // Later speed changes must not move the square before the next pulse
            speed = 3'($urandom_range(0, 7));
            probe(m_sx, m_sy, 1'b1, "rnd_tl");
            probe(m_sx + SIZE - 1, m_sy + SIZE - 1, 1'b1, "rnd_br");
            if (m_sx > 0) probe(m_sx - 1, m_sy, 1'b1, "rnd_left");
            if (m_sy + SIZE < 480) probe(m_sx, m_sy + SIZE, 1'b1, "rnd_below");
            probe($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)), "rnd_any");
        end
    endtask

    task automatic test_reset_mid_run();
        do_animate(3, 1'b1, 1'b1);
        xPos = 10'(m_sx);
        yPos = 9'(m_sy);
        active = 1'b1;
        hSync_in = 1'b0;
        vSync_in = 1'b0;
        pixel_strobe = 1'b1;
        animate = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        animate = 1'b0;
        pixel_strobe = 1'b0;
        hSync_in = 1'b1;
        vSync_in = 1'b1;
        model_reset();
        tests_run++;
        if (rgb !== 12'h000 || hSync_out !== 1'b1 || vSync_out !== 1'b1 ||
            bounce_count !== 8'd0 || hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got rgb=%03h hs=%0b vs=%0b bc=%0d hit=%0b expected 000 1 1 0 0",
                     rgb, hSync_out, vSync_out, bounce_count, hit);
        end
        probe(304, 224, 1'b1, "after_reset");
        do_animate(5, 1'b1, 1'b1);
        probe(304, 224, 1'b1, "after_reset_idle_exit");
    endtask

    task automatic test_saturation();
        int extra = 0;
        int iter = 0;
        apply_reset();
        while (extra < 5 && iter < 15000) begin
            do_animate(7, 1'b1, 1'b0);
            if (m_hit) begin
                $display("[TB] bounce sq=(%0d,%0d) bc=%0d", m_sx, m_sy, bounce_count);
                if (m_bc == 255) extra++;
            end
            iter++;
        end
        tests_run++;
        if (extra < 5) begin
            tests_failed++;
            $display("FAIL saturation_budget: got %0d post-saturation bounces expected 5", extra);
        end
        tests_run++;
        if (bounce_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL saturation_value: got %0d expected 255", bounce_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_hold();
        test_start_move();
        test_pixel_pipeline();
        test_random_run();
        test_reset_mid_run();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
